// File: rtl/sram_bus_arbiter_pkg.sv
// Shared request-ID and transfer-size encodings for the sram bus arbiter
// and the blocks that sit around it.
package sram_bus_arbiter_pkg;

  typedef enum logic {
    REQ_ID_INST = 1'b0,
    REQ_ID_DATA = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_ID_INST) ? REQ_ID_DATA : REQ_ID_INST;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_id_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding the requester ID of each accepted
// transaction until its response comes back. DEPTH must be a power of 2.
module id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    dout  = mem[rd_ptr];
    full  = (count == FULL_CNT);
    empty = (count == '0);
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like master port between the inst and data requesters and
// routes in-order responses back by recorded ID. ARB_RR_EN selects round-robin.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  req_id_e winner;
  req_id_e grant;
  req_id_e lock_id;
  logic    lock_vld;
  logic    grant_req;
  logic    accept;
  logic    resp_pop;
  logic    fifo_head;
  logic    fifo_full;
  logic    fifo_empty;
  logic [$clog2(MAX_OUTST):0] fifo_count;

`ifdef ARB_RR_EN
  req_id_e last_grant;

  // On contention the requester not served last wins; reset value of INST
  // lets data win the first contested cycle.
  always_comb begin
    winner = REQ_ID_INST;
    if (inst_req && data_req)
      winner = other_id(last_grant);
    else if (data_req)
      winner = REQ_ID_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= REQ_ID_INST;
    else if (accept)
      last_grant <= grant;
  end
`else
  always_comb begin
    winner = data_req ? REQ_ID_DATA : REQ_ID_INST;
  end
`endif

  always_comb begin
    grant     = lock_vld ? lock_id : winner;
    grant_req = (grant == REQ_ID_DATA) ? data_req : inst_req;
    m_req     = grant_req && !fifo_full && !reset;
    accept    = m_req && m_addr_ok;
    resp_pop  = m_data_ok && !fifo_empty && !reset;
  end

  always_comb begin
    if (grant == REQ_ID_DATA) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_wstrb = data_wstrb;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_wstrb = inst_wstrb;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end
  end

  // Hold the grant while the slave stalls so m_* stays stable until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_id  <= REQ_ID_INST;
    end else if (lock_vld) begin
      if (m_addr_ok)
        lock_vld <= 1'b0;
    end else if (m_req && !m_addr_ok) begin
      lock_vld <= 1'b1;
      lock_id  <= grant;
    end
  end

  id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (resp_pop),
    .din   (grant),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    inst_addr_ok = accept && (grant == REQ_ID_INST);
    data_addr_ok = accept && (grant == REQ_ID_DATA);
    inst_data_ok = resp_pop && (fifo_head == logic'(REQ_ID_INST));
    data_data_ok = resp_pop && (fifo_head == logic'(REQ_ID_DATA));
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: vector table plus hand sequences, with a queue
// of expected response IDs consumed as m_data_ok is driven.
module tb_sram_bus_arbiter;

  localparam logic [31:0] IA = 32'h1c000000;
  localparam logic [31:0] DA = 32'h80001000;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        exp_q[$];

  sram_bus_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_OUTST (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_wstrb      (m_wstrb),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .m_rdata      (m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rd;
    logic        e_mreq, e_iaok, e_daok;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle (inputs just after posedge), check mid-cycle, advance.
  task automatic apply(input string tag, input logic ir, input logic dr, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic e_mreq,
                       input logic e_iaok, input logic e_daok, input logic [31:0] e_maddr);
    logic exp_id, e_idok, e_ddok;
    inst_req  = ir;
    data_req  = dr;
    m_addr_ok = aok;
    m_data_ok = dok;
    m_rdata   = rd;
    #4;
    check({tag, " m_req"}, 32'(m_req), 32'(e_mreq));
    if (e_mreq) begin
      check({tag, " m_addr"}, m_addr, e_maddr);
      check({tag, " m_wr"}, 32'(m_wr), 32'(e_maddr == DA));
    end
    check({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(e_iaok));
    check({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'(e_daok));
    e_idok = 1'b0;
    e_ddok = 1'b0;
    if (dok && exp_q.size() > 0) begin
      exp_id = exp_q.pop_front();
      e_idok = !exp_id;
      e_ddok = exp_id;
    end
    check({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'(e_idok));
    check({tag, " data_data_ok"}, 32'(data_data_ok), 32'(e_ddok));
    if (e_idok) check({tag, " inst_rdata"}, inst_rdata, rd);
    if (e_ddok) check({tag, " data_rdata"}, data_rdata, rd);
    if (e_iaok) exp_q.push_back(1'b0);
    if (e_daok) exp_q.push_back(1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 32'h0,  0, 0, 0, 32'h0};
    vecs[1]  = '{1, 1, 1, 0, 32'h0,  1, 0, 1, DA};
    vecs[2]  = '{1, 0, 1, 0, 32'h0,  1, 1, 0, IA};
    vecs[3]  = '{0, 0, 0, 1, 32'h22, 0, 0, 0, 32'h0};
    vecs[4]  = '{0, 0, 0, 1, 32'h11, 0, 0, 0, 32'h0};
    vecs[5]  = '{0, 1, 0, 0, 32'h0,  1, 0, 0, DA};
    vecs[6]  = '{1, 1, 0, 0, 32'h0,  1, 0, 0, DA};
    vecs[7]  = '{1, 1, 0, 0, 32'h0,  1, 0, 0, DA};
    vecs[8]  = '{1, 1, 1, 0, 32'h0,  1, 0, 1, DA};
    vecs[9]  = '{1, 0, 1, 0, 32'h0,  1, 1, 0, IA};
    vecs[10] = '{0, 0, 0, 1, 32'h44, 0, 0, 0, 32'h0};
    vecs[11] = '{0, 0, 0, 1, 32'h55, 0, 0, 0, 32'h0};
    vecs[12] = '{1, 0, 0, 0, 32'h0,  1, 0, 0, IA};
    vecs[13] = '{1, 1, 0, 0, 32'h0,  1, 0, 0, IA};
    vecs[14] = '{1, 1, 1, 0, 32'h0,  1, 1, 0, IA};
    vecs[15] = '{0, 1, 1, 0, 32'h0,  1, 0, 1, DA};
    vecs[16] = '{1, 0, 1, 0, 32'h0,  1, 1, 0, IA};
    vecs[17] = '{0, 0, 0, 1, 32'h11, 0, 0, 0, 32'h0};
    vecs[18] = '{0, 0, 0, 1, 32'h22, 0, 0, 0, 32'h0};
    vecs[19] = '{0, 0, 0, 1, 32'h33, 0, 0, 0, 32'h0};
    vecs[20] = '{0, 0, 0, 1, 32'h99, 0, 0, 0, 32'h0};

    inst_wr = 1'b0;  inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = IA; inst_wdata = 32'h0;
    data_wr = 1'b1;  data_size = 2'd2; data_wstrb = 4'hf; data_addr = DA; data_wdata = 32'hcafef00d;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;

    // Reset held with both requesters active: nothing may be offered.
    reset = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset m_req", 32'(m_req), 32'h0);
    check("reset inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    check("reset data_addr_ok", 32'(data_addr_ok), 32'h0);
    inst_req = 1'b0; data_req = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check("reset count", 32'(dut.u_id_fifo.count), 32'h0);

    for (int i = 0; i < 21; i++)
      apply($sformatf("v%0d", i), vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok, vecs[i].rd,
            vecs[i].e_mreq, vecs[i].e_iaok, vecs[i].e_daok, vecs[i].e_maddr);

    // Fill to MAX_OUTST, stall while full, reassert the cycle after a pop.
    for (int i = 0; i < 4; i++)
      apply($sformatf("fill%0d", i), 1, 0, 1, 0, 32'h0, 1, 1, 0, IA);
    check("full count", 32'(dut.u_id_fifo.count), 32'd4);
    apply("full_stall", 1, 0, 1, 0, 32'h0, 0, 0, 0, IA);
    apply("full_pop", 1, 0, 1, 1, 32'ha0, 0, 0, 0, IA);
    apply("full_reassert", 1, 0, 1, 0, 32'h0, 1, 1, 0, IA);
    for (int i = 0; i < 4; i++)
      apply($sformatf("drain%0d", i), 0, 0, 0, 1, 32'hb0 + 32'(i), 0, 0, 0, 32'h0);
    check("drained count", 32'(dut.u_id_fifo.count), 32'h0);

    // Push and pop in the same cycle keep the count and the order.
    apply("pp_a", 1, 0, 1, 0, 32'h0, 1, 1, 0, IA);
    apply("pp_b", 0, 1, 1, 0, 32'h0, 1, 0, 1, DA);
    apply("pp_both", 1, 0, 1, 1, 32'h05, 1, 1, 0, IA);
    check("pp count", 32'(dut.u_id_fifo.count), 32'd2);
    apply("pp_r1", 0, 0, 0, 1, 32'h06, 0, 0, 0, 32'h0);
    apply("pp_r2", 0, 0, 0, 1, 32'h07, 0, 0, 0, 32'h0);

    // Reset with two outstanding: the late response must be dropped.
    apply("rst_a", 1, 0, 1, 0, 32'h0, 1, 1, 0, IA);
    apply("rst_b", 0, 1, 1, 0, 32'h0, 1, 0, 1, DA);
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset count", 32'(dut.u_id_fifo.count), 32'h0);
    apply("rst_drop", 0, 0, 0, 1, 32'hbb, 0, 0, 0, 32'h0);
    apply("rst_new", 1, 0, 1, 0, 32'h0, 1, 1, 0, IA);
    apply("rst_resp", 0, 0, 0, 1, 32'hcc, 0, 0, 0, 32'h0);

    // Continuous contention.
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      if (i % 2 == 0)
        apply($sformatf("rr%0d", i), 1, 1, 1, 0, 32'h0, 1, 0, 1, DA);
      else
        apply($sformatf("rr%0d", i), 1, 1, 1, 0, 32'h0, 1, 1, 0, IA);
`else
      apply($sformatf("fix%0d", i), 1, 1, 1, 0, 32'h0, 1, 0, 1, DA);
`endif
    end
    for (int i = 0; i < 4; i++)
      apply($sformatf("cdrain%0d", i), 0, 0, 0, 1, 32'hd0 + 32'(i), 0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
